// File: rtl/log_perf_pkg.sv
// Shared widths and FSM state type for the log/perf sideband controller.
package log_perf_pkg;

  localparam int LP_TIMER_W    = 64;
  localparam int LP_INTERVAL_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DUMP  = 2'd1,
    CLEAN = 2'd2,
    HALT  = 2'd3
  } log_perf_state_e;

endpackage

// File: rtl/log_perf_if.sv
// Log/perf sideband bundle: host config/requests in, timer/window/strobes out.
interface log_perf_if
  import log_perf_pkg::*;
#(
  parameter int TIMER_W    = LP_TIMER_W,
  parameter int INTERVAL_W = LP_INTERVAL_W
);

  logic [TIMER_W-1:0]    log_begin;
  logic [TIMER_W-1:0]    log_end;
  logic [INTERVAL_W-1:0] perf_interval;
  logic                  dump_req;
  logic                  clean_req;
  logic                  finish;
  logic [TIMER_W-1:0]    timer;
  logic                  logEnable;
  logic                  clean;
  logic                  dump;
  logic                  halted;

  modport master (
    output log_begin, log_end, perf_interval, dump_req, clean_req, finish,
    input  timer, logEnable, clean, dump, halted
  );

  modport slave (
    input  log_begin, log_end, perf_interval, dump_req, clean_req, finish,
    output timer, logEnable, clean, dump, halted
  );

endinterface

// File: rtl/log_perf_interval_timer.sv
// Periodic-dump down-counter: reloads perf_interval-1 on reset and on each fire.
// perf_interval==0 parks the counter at zero without firing.
module perf_interval_timer #(
  parameter int INTERVAL_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INTERVAL_W-1:0] perf_interval_i,
  output logic                  fire_o
);

  logic [INTERVAL_W-1:0] cnt_q, cnt_d, reload;
  logic                  ivl_zero;

  assign ivl_zero = (perf_interval_i == '0);
  assign reload   = ivl_zero ? '0 : perf_interval_i - INTERVAL_W'(1);
  assign fire_o   = (cnt_q == '0) && !ivl_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (fire_o) begin
      cnt_d = reload;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - INTERVAL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/log_perf_ctrl.sv
// Log/perf sideband controller: cycle timer, log window, one-cycle dump/clean strobes, final halt.
// Define LOG_PERF_CLEAN_AFTER_DUMP_EN to follow every non-final dump with a clean strobe.
module log_perf_ctrl
  import log_perf_pkg::*;
#(
  parameter int TIMER_W    = LP_TIMER_W,
  parameter int INTERVAL_W = LP_INTERVAL_W
) (
  input logic       clock,
  input logic       reset,
  log_perf_if.slave bus
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               log_en_q, log_en_d;
  log_perf_state_e    state_q, state_d;
  logic               final_q, final_d;
  logic               fin_pend_q, fin_pend_d;
  logic               pend_dump_q, pend_dump_d;
  logic               pend_clean_q, pend_clean_d;
  logic               dump_q, clean_q, halted_q;
  logic               fire;

  perf_interval_timer #(.INTERVAL_W(INTERVAL_W)) u_interval (
    .clock          (clock),
    .reset          (reset),
    .perf_interval_i(bus.perf_interval),
    .fire_o         (fire)
  );

  // Window is evaluated on the next timer value so the registered flag lines up with timer_q.
  assign timer_d  = timer_q + TIMER_W'(1);
  assign log_en_d = (timer_d >= bus.log_begin) && (timer_d < bus.log_end);

  always_comb begin
    state_d      = state_q;
    final_d      = final_q;
    fin_pend_d   = fin_pend_q;
    pend_dump_d  = pend_dump_q;
    pend_clean_d = pend_clean_q;

    if (state_q != HALT) begin
      if (bus.dump_req || (fire && state_q != RUN)) pend_dump_d = 1'b1;
      if (bus.clean_req && state_q != CLEAN)        pend_clean_d = 1'b1;
      if (bus.finish && state_q != RUN)             fin_pend_d = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        if (bus.finish || fin_pend_q) begin
          state_d = DUMP;
          final_d = 1'b1;
        end else if (fire || bus.dump_req || pend_dump_q) begin
          state_d = DUMP;
        end else if (bus.clean_req || pend_clean_q) begin
          state_d = CLEAN;
        end
      end
      DUMP: begin
        if (final_q) begin
          state_d = HALT;
        end else begin
`ifdef LOG_PERF_CLEAN_AFTER_DUMP_EN
          state_d = CLEAN;
`else
          state_d = RUN;
`endif
        end
      end
      CLEAN:   state_d = RUN;
      default: state_d = HALT;
    endcase

    if (state_d == DUMP && state_q != DUMP) begin
      pend_dump_d = 1'b0;
      if (final_d) fin_pend_d = 1'b0;
    end
    if (state_d == CLEAN && state_q != CLEAN) pend_clean_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q      <= '0;
      log_en_q     <= 1'b0;
      state_q      <= RUN;
      final_q      <= 1'b0;
      fin_pend_q   <= 1'b0;
      pend_dump_q  <= 1'b0;
      pend_clean_q <= 1'b0;
      dump_q       <= 1'b0;
      clean_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      log_en_q     <= log_en_d;
      state_q      <= state_d;
      final_q      <= final_d;
      fin_pend_q   <= fin_pend_d;
      pend_dump_q  <= pend_dump_d;
      pend_clean_q <= pend_clean_d;
      dump_q       <= (state_d == DUMP);
      clean_q      <= (state_d == CLEAN);
      halted_q     <= (state_d == HALT);
    end
  end

  assign bus.timer     = timer_q;
  assign bus.logEnable = log_en_q;
  assign bus.dump      = dump_q;
  assign bus.clean     = clean_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_log_perf_ctrl.sv
// Bench for log_perf_ctrl: directed scenarios plus random requests against a strobe-level model.
// Narrow timer so wrap-around is reached by counting.
module tb_log_perf_ctrl;
  import log_perf_pkg::*;

  localparam int TW = 10;
  localparam int IW = 8;
`ifdef LOG_PERF_CLEAN_AFTER_DUMP_EN
  localparam bit CAD = 1'b1;
`else
  localparam bit CAD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  log_perf_if #(.TIMER_W(TW), .INTERVAL_W(IW)) bus ();

  log_perf_ctrl #(.TIMER_W(TW), .INTERVAL_W(IW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: expected outputs after each edge.
  logic [TW-1:0] m_timer;
  bit m_len, m_dump, m_clean, m_halt, m_final;
  bit w_dump, w_clean, w_fin;
  int cyc;
  int per;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit in_run, fire, nd, nc, nh;
    if (reset) begin
      m_timer = '0; m_len = 0; m_dump = 0; m_clean = 0; m_halt = 0; m_final = 0;
      w_dump = 0; w_clean = 0; w_fin = 0; cyc = 0;
      per = int'(bus.perf_interval);
    end else begin
      in_run = !m_dump && !m_clean && !m_halt;
      fire = (per != 0) && (((cyc + 1) % per) == 0);
      nd = 0; nc = 0; nh = m_halt;
      if (!m_halt) begin
        if (bus.dump_req || (fire && !in_run)) w_dump = 1;
        if (bus.clean_req && !m_clean) w_clean = 1;
        if (bus.finish && !in_run) w_fin = 1;
        if (m_dump) begin
          if (m_final) nh = 1;
          else if (CAD) nc = 1;
        end else if (in_run) begin
          if (bus.finish || w_fin) begin nd = 1; m_final = 1; end
          else if (fire || bus.dump_req || w_dump) nd = 1;
          else if (bus.clean_req || w_clean) nc = 1;
        end
        if (nd) begin w_dump = 0; if (m_final) w_fin = 0; end
        if (nc) w_clean = 0;
      end
      m_dump = nd; m_clean = nc; m_halt = nh;
      m_timer = m_timer + TW'(1);
      m_len = (m_timer >= bus.log_begin) && (m_timer < bus.log_end);
      cyc++;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    chk("timer", 64'(bus.timer), 64'(m_timer));
    chk("logEnable", 64'(bus.logEnable), 64'(m_len));
    chk("dump", 64'(bus.dump), 64'(m_dump));
    chk("clean", 64'(bus.clean), 64'(m_clean));
    chk("halted", 64'(bus.halted), 64'(m_halt));
  endtask

  task automatic do_reset(input int p, input int lb, input int le);
    bus.perf_interval = IW'(p);
    bus.log_begin = TW'(lb);
    bus.log_end = TW'(le);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, nd, nc, fd, fc, guard;
    reset = 1'b1;
    bus.dump_req = 0; bus.clean_req = 0; bus.finish = 0;
    bus.perf_interval = '0; bus.log_begin = '0; bus.log_end = '0;
    @(negedge clock);

    // Reset state
    do_reset(0, 10, 20);
    chk("rst_timer", 64'(bus.timer), 0);
    chk("rst_halted", 64'(bus.halted), 0);

    // 1: window [10,20) then inverted window
    n = 0;
    repeat (30) begin step(); if (bus.logEnable) n++; end
    chk("win_count", 64'(n), 10);
    do_reset(0, 20, 10);
    n = 0;
    repeat (30) begin step(); if (bus.logEnable) n++; end
    chk("win_inverted", 64'(n), 0);

    // 2: periodic dumps every 5 cycles
    do_reset(5, 0, 0);
    nd = 0; nc = 0; fd = -1; fc = -1;
    repeat (30) begin
      step();
      if (bus.dump) begin nd++; if (fd < 0) fd = int'(bus.timer); end
      if (bus.clean) begin nc++; if (fc < 0) fc = int'(bus.timer); end
    end
    chk("p5_dumps", 64'(nd), 6);
    chk("p5_first_dump", 64'(fd), 5);
    chk("p5_cleans", 64'(nc), CAD ? 5 : 0);
    if (CAD) chk("p5_first_clean", 64'(fc), 6);

    // 3: simultaneous dump_req and clean_req
    do_reset(0, 0, 0);
    step(); step();
    bus.dump_req = 1; bus.clean_req = 1;
    step();
    bus.dump_req = 0; bus.clean_req = 0;
    chk("both_dump_latency", 64'(bus.dump), 1);
    nd = 1; nc = 0;
    repeat (6) begin step(); if (bus.dump) nd++; if (bus.clean) nc++; end
    chk("both_dumps", 64'(nd), 1);
    chk("both_cleans", 64'(nc), 1);

    // 4: finish during CLEAN at timer 100
    do_reset(0, 0, 0);
    guard = 0;
    while (bus.timer != TW'(99) && guard < 300) begin step(); guard++; end
    chk("fin_reach99", 64'(bus.timer), 99);
    bus.clean_req = 1;
    step();
    bus.clean_req = 0;
    chk("fin_clean_at100", 64'(bus.clean), 1);
    bus.finish = 1;
    step();
    bus.finish = 0;
    step();
    chk("fin_dump_timer", 64'(bus.timer), 102);
    chk("fin_dump", 64'(bus.dump), 1);
    step();
    chk("fin_halted", 64'(bus.halted), 1);
    bus.dump_req = 1; bus.clean_req = 1; bus.finish = 1;
    step();
    bus.dump_req = 0; bus.clean_req = 0; bus.finish = 0;
    n = 0;
    repeat (6) begin step(); if (bus.dump || bus.clean) n++; end
    chk("halt_no_strobes", 64'(n), 0);
    chk("halt_timer_runs", 64'(bus.timer), 110);

    // 5: reset during DUMP, interval 3
    do_reset(3, 0, 0);
    guard = 0;
    while (!bus.dump && guard < 20) begin step(); guard++; end
    chk("rd_dump_seen", 64'(bus.dump), 1);
    reset = 1;
    step();
    reset = 0;
    chk("rd_dump_cleared", 64'(bus.dump), 0);
    chk("rd_timer_zero", 64'(bus.timer), 0);
    guard = 0;
    while (!bus.dump && guard < 20) begin step(); guard++; end
    chk("rd_first_dump_timer", 64'(bus.timer), 3);

    // 6: timer wrap
    do_reset(0, 1, 5);
    guard = 0;
    while (bus.timer != TW'((1 << TW) - 2) && guard < 1100) begin step(); guard++; end
    chk("wrap_reach", 64'(bus.timer), (1 << TW) - 2);
    step(); step();
    chk("wrap_zero", 64'(bus.timer), 0);
    step();
    chk("wrap_window", 64'(bus.logEnable), 1);

    // Random segments
    for (int s = 0; s < 8; s++) begin
      do_reset(int'($urandom_range(0, 6)), int'($urandom_range(0, 40)), int'($urandom_range(0, 60)));
      repeat (250) begin
        bus.dump_req = ($urandom_range(0, 15) == 0);
        bus.clean_req = ($urandom_range(0, 11) == 0);
        bus.finish = ($urandom_range(0, 199) == 0);
        step();
      end
      bus.dump_req = 0; bus.clean_req = 0; bus.finish = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
